// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants and fetch FSM encoding for the MIPS front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR       = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/mips_if_perf_ctr.sv
// ============================================================================
// Module   : mips_if_perf_ctr
// Purpose  : Free-running 32-bit event counter, wraps at 2^32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_if_perf_ctr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : mips_if_perf_ctr

`default_nettype wire

// File: rtl/mips_if_stage.sv
// ============================================================================
// Module   : mips_if_stage
// Purpose  : MIPS instruction-fetch stage with IF/ID register and BOOT/RUN/HALT
//            control. Performance counters built only with MIPS_IF_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr_if,
  output logic [31:0] next_pc_if,
  output logic        valid_if,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count,
  output logic [31:0] stall_count
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_instr, w_instr_nxt;
  logic [31:0]  r_next_pc, w_next_pc_nxt;
  logic         r_valid, w_valid_nxt;
  logic [31:0]  w_pc_inc;
  logic         w_unused;

  // 32-bit add wraps naturally modulo 2^32
  assign w_pc_inc = r_pc + PC_STEP;
  // Redirect targets are word-aligned; the low bits are dropped
  assign w_unused = ^branch_target[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_next_pc <= RESET_PC;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_next_pc <= w_next_pc_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_next_pc_nxt = r_next_pc;
    w_valid_nxt   = r_valid;
    if (clk_en) begin
      unique case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // Redirect wins over stall and also suppresses a coincident HALT word
          if (branch_taken) begin
            w_pc_nxt    = {branch_target[31:2], 2'b00};
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
          end else if (!stall) begin
            w_pc_nxt      = w_pc_inc;
            w_instr_nxt   = imem_rdata;
            w_next_pc_nxt = w_pc_inc;
            w_valid_nxt   = 1'b1;
            if (imem_rdata == HALT_INSTR) begin
              w_state_nxt = ST_HALT;
            end
          end
        end
        ST_HALT: begin
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign instr_if   = r_instr;
  assign next_pc_if = r_next_pc;
  assign valid_if   = r_valid;
  assign halted     = (r_state == ST_HALT);

`ifdef MIPS_IF_PERF_EN
  logic w_run_en;
  logic w_fetch_evt;
  logic w_flush_evt;
  logic w_stall_evt;

  assign w_run_en    = clk_en && (r_state == ST_RUN);
  assign w_fetch_evt = w_run_en && !branch_taken && !stall;
  assign w_flush_evt = w_run_en && branch_taken;
  assign w_stall_evt = w_run_en && !branch_taken && stall;

  mips_if_perf_ctr #(.WIDTH(32)) u_fetch_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_fetch_evt),
    .count (fetch_count)
  );

  mips_if_perf_ctr #(.WIDTH(32)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_evt),
    .count (flush_count)
  );

  mips_if_perf_ctr #(.WIDTH(32)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_evt),
    .count (stall_count)
  );
`else
  assign fetch_count = 32'd0;
  assign flush_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule : mips_if_stage

`default_nettype wire

// File: tb/tb_mips_if_stage.sv
// ============================================================================
// Module   : tb_mips_if_stage
// Purpose  : Directed self-checking bench for mips_if_stage (default and
//            wrapping RESET_PC instances driven from shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;

  logic [31:0] a_imem_addr, a_pc, a_instr, a_next_pc;
  logic        a_valid, a_halted;
  logic [31:0] a_fetch, a_flush, a_stall;
  logic [31:0] w_imem_addr, w_pc, w_instr, w_next_pc;
  logic        w_valid, w_halted;
  logic [31:0] w_fetch, w_flush, w_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (a_imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (a_pc),
    .instr_if      (a_instr),
    .next_pc_if    (a_next_pc),
    .valid_if      (a_valid),
    .halted        (a_halted),
    .fetch_count   (a_fetch),
    .flush_count   (a_flush),
    .stall_count   (a_stall)
  );

  mips_if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (w_imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (w_pc),
    .instr_if      (w_instr),
    .next_pc_if    (w_next_pc),
    .valid_if      (w_valid),
    .halted        (w_halted),
    .fetch_count   (w_fetch),
    .flush_count   (w_flush),
    .stall_count   (w_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected counter value: the value itself when counters are built, else 0
  function automatic logic [31:0] ctr(input logic [31:0] v);
`ifdef MIPS_IF_PERF_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk_en        = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    imem_rdata    = 32'h2001_0005;

    // Asynchronous reset takes effect before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_pc",      a_pc, 32'h0);
    check("rst_addr",    a_imem_addr, 32'h0);
    check("rst_instr",   a_instr, 32'h0);
    check("rst_next_pc", a_next_pc, 32'h0);
    check("rst_valid",   {31'd0, a_valid}, 32'd0);
    check("rst_halted",  {31'd0, a_halted}, 32'd0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("rst_wrap_np", w_next_pc, 32'hFFFF_FFFC);
    check("rst_fetch",   a_fetch, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // BOOT cycle: no fetch
    tick();
    check("boot_pc",    a_pc, 32'h0);
    check("boot_valid", {31'd0, a_valid}, 32'd0);
    check("boot_fetch", a_fetch, 32'd0);
    tick();
    check("f0_pc",      a_pc, 32'h4);
    check("f0_instr",   a_instr, 32'h2001_0005);
    check("f0_next_pc", a_next_pc, 32'h4);
    check("f0_valid",   {31'd0, a_valid}, 32'd1);
    tick();
    check("f1_pc",      a_pc, 32'h8);
    check("f1_instr",   a_instr, 32'h2001_0005);
    check("f1_next_pc", a_next_pc, 32'h8);
    tick();
    tick();
    check("f3_pc",    a_pc, 32'h10);
    check("f3_fetch", a_fetch, ctr(32'd4));

    // Stall for three cycles at 0x10
    stall      = 1'b1;
    imem_rdata = 32'h2222_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",      a_pc, 32'h10);
      check("stall_instr",   a_instr, 32'h2001_0005);
      check("stall_next_pc", a_next_pc, 32'h10);
    end
    check("stall_cnt", a_stall, ctr(32'd3));
    stall = 1'b0;
    tick();
    check("resume_pc",    a_pc, 32'h14);
    check("resume_instr", a_instr, 32'h2222_0010);
    check("resume_np",    a_next_pc, 32'h14);
    check("resume_fetch", a_fetch, ctr(32'd5));

    // Branch beats a simultaneous stall; target is word-aligned
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 32'h0000_0043;
    tick();
    check("br_pc",    a_pc, 32'h40);
    check("br_instr", a_instr, 32'h0);
    check("br_valid", {31'd0, a_valid}, 32'd0);
    check("br_flush", a_flush, ctr(32'd1));
    check("br_stall", a_stall, ctr(32'd3));
    stall         = 1'b0;
    branch_target = 32'h0000_001E;
    tick();
    check("br2_pc", a_pc, 32'h1C);

    // HALT word arriving together with a branch: branch taken, no halt
    imem_rdata    = 32'hFFFF_FFFF;
    branch_target = 32'h0000_001C;
    tick();
    check("brh_pc",     a_pc, 32'h1C);
    check("brh_halted", {31'd0, a_halted}, 32'd0);
    check("brh_valid",  {31'd0, a_valid}, 32'd0);
    check("brh_flush",  a_flush, ctr(32'd3));
    branch_taken = 1'b0;
    imem_rdata   = 32'h3333_0000;
    tick();
    check("pre_halt_pc", a_pc, 32'h20);

    // Halt fetch at 0x20
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    check("halt_pc",     a_pc, 32'h24);
    check("halt_instr",  a_instr, 32'hFFFF_FFFF);
    check("halt_valid",  {31'd0, a_valid}, 32'd1);
    check("halt_halted", {31'd0, a_halted}, 32'd1);
    check("halt_fetch",  a_fetch, ctr(32'd7));
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 32'h0000_0100;
    imem_rdata    = 32'h4444_0000;
    tick();
    tick();
    check("hold_pc",     a_pc, 32'h24);
    check("hold_instr",  a_instr, 32'h0);
    check("hold_valid",  {31'd0, a_valid}, 32'd0);
    check("hold_halted", {31'd0, a_halted}, 32'd1);
    check("hold_flush",  a_flush, ctr(32'd3));
    check("hold_stall",  a_stall, ctr(32'd3));

    // Reset pulse leaves HALT
    branch_taken = 1'b0;
    stall        = 1'b0;
    imem_rdata   = 32'h1234_5678;
    reset        = 1'b1;
    #1;
    check("rp_pc",     a_pc, 32'h0);
    check("rp_halted", {31'd0, a_halted}, 32'd0);
    check("rp_fetch",  a_fetch, 32'd0);
    check("rp_flush",  a_flush, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("wrap_pc",    w_pc, 32'h0);
    check("wrap_np",    w_next_pc, 32'h0);
    check("wrap_instr", w_instr, 32'h1234_5678);
    check("post_rst_pc", a_pc, 32'h4);

    // clk_en low freezes everything regardless of other inputs
    clk_en        = 1'b0;
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 32'h0000_0080;
    imem_rdata    = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      branch_taken = ~branch_taken;
      check("ce_wrap_pc", w_pc, 32'h0);
      check("ce_pc",      a_pc, 32'h4);
    end
    check("ce_instr",  a_instr, 32'h1234_5678);
    check("ce_np",     a_next_pc, 32'h4);
    check("ce_valid",  {31'd0, a_valid}, 32'd1);
    check("ce_halted", {31'd0, a_halted}, 32'd0);
    check("ce_fetch",  a_fetch, ctr(32'd1));
    check("ce_flush",  a_flush, 32'd0);
    check("ce_stall",  a_stall, 32'd0);
    check("ce_wfetch", w_fetch, ctr(32'd1));
    check("ce_wflush", w_flush + w_stall, 32'd0);
    check("ce_wvalid", {30'd0, w_valid, w_halted}, 32'd2);
    check("ce_waddr",  w_imem_addr, 32'h0);
    clk_en       = 1'b1;
    branch_taken = 1'b0;
    stall        = 1'b0;
    imem_rdata   = 32'h0000_0001;
    tick();
    check("ce_resume_wpc", w_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mips_if_stage

`default_nettype wire
